// File: rtl/ramen_order_engine_if.sv
// Order, restock and reporting bundle for the ramen order engine.
// Master side is the front-of-house sequencer; slave side is the engine.
interface ramen_order_engine_if #(
  parameter int QTY_W  = 3,
  parameter int CNT_W  = 8,
  parameter int GAIN_W = 18
);
  logic                 selling;
  logic                 in_valid;
  logic [1:0]           ramen_type;
  logic                 portion;
  logic [QTY_W-1:0]     qty;
  logic                 restock_valid;
  logic [2:0]           restock_sel;
  logic [15:0]          restock_amt;
  logic                 order_ready;
  logic                 out_valid_order;
  logic                 success;
  logic [4:0]           low_stock;
  logic                 out_valid_tot;
  logic [4*CNT_W-1:0]   sold_num;
  logic [GAIN_W-1:0]    total_gain;

  modport master (
    output selling, in_valid, ramen_type, portion, qty,
    output restock_valid, restock_sel, restock_amt,
    input  order_ready, out_valid_order, success, low_stock,
    input  out_valid_tot, sold_num, total_gain
  );

  modport slave (
    input  selling, in_valid, ramen_type, portion, qty,
    input  restock_valid, restock_sel, restock_amt,
    output order_ready, out_valid_order, success, low_stock,
    output out_valid_tot, sold_num, total_gain
  );
endinterface

// File: rtl/ramen_order_engine.sv
// Ramen order engine: recipe check, stock deduction, restock and
// saturating per-type sales counters with end-of-session totals.
module ramen_order_engine #(
  parameter int         QTY_W    = 3,
  parameter int         CNT_W    = 8,
  parameter int         GAIN_W   = 18,
  parameter logic [7:0] PRICE_T  = 8'd200,
  parameter logic [7:0] PRICE_TS = 8'd250,
  parameter logic [7:0] PRICE_M  = 8'd200,
  parameter logic [7:0] PRICE_MS = 8'd250,
  parameter int         LOW_THR  = 1000
) (
  input logic                clk,
  input logic                rst,
  ramen_order_engine_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, OPEN, CHECK, DECIDE, TOTAL
  } state_t;

  state_t state, state_nx;

  logic [1:0]         type_r;
  logic               portion_r;
  logic [QTY_W-1:0]   qty_r;
  logic [15:0]        unit [5];
  logic [15:0]        need [5];
  logic [15:0]        inv [5];
  logic [15:0]        inv_nx [5];
  logic [15:0]        base [5];
  logic [15:0]        add [5];
  logic [16:0]        sum [5];
  logic [CNT_W-1:0]   cnt [4];
  logic [CNT_W:0]     cnt_sum;
  logic [4:0]         low_q;
  logic [GAIN_W-1:0]  gain;
  logic               ok;
  logic               take;
  logic               accept;

  function automatic logic [15:0] init_inv(input int i);
    case (i)
      0:       return 16'd12000;
      1:       return 16'd41000;
      2:       return 16'd9000;
      3:       return 16'd1000;
      default: return 16'd1500;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (bus.selling) state_nx = OPEN;
      OPEN: begin
        if (!bus.selling)     state_nx = TOTAL;
        else if (bus.in_valid) state_nx = CHECK;
      end
      CHECK:  state_nx = DECIDE;
      DECIDE: state_nx = OPEN;
      TOTAL:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign accept = (state == OPEN) && bus.selling && bus.in_valid;
  assign take   = (state == DECIDE) && ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      type_r    <= '0;
      portion_r <= 1'b0;
      qty_r     <= '0;
    end else if (accept) begin
      type_r    <= bus.ramen_type;
      portion_r <= bus.portion;
      qty_r     <= bus.qty;
    end
  end

  // Per-serving recipe, index order: noodle, broth, tonkotsu, miso, soy
  always_comb begin
    for (int i = 0; i < 5; i++) unit[i] = '0;
    unit[0] = portion_r ? 16'd150 : 16'd100;
    unique case (type_r)
      2'd0: begin
        unit[1] = portion_r ? 16'd500 : 16'd300;
        unit[2] = portion_r ? 16'd200 : 16'd150;
      end
      2'd1: begin
        unit[1] = portion_r ? 16'd500 : 16'd300;
        unit[2] = portion_r ? 16'd150 : 16'd100;
        unit[4] = portion_r ? 16'd50  : 16'd30;
      end
      2'd2: begin
        unit[1] = portion_r ? 16'd650 : 16'd400;
        unit[3] = portion_r ? 16'd50  : 16'd30;
      end
      2'd3: begin
        unit[1] = portion_r ? 16'd500 : 16'd300;
        unit[2] = portion_r ? 16'd100 : 16'd70;
        unit[3] = portion_r ? 16'd25  : 16'd15;
        unit[4] = portion_r ? 16'd25  : 16'd15;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) need[i] <= '0;
    end else if (state == CHECK) begin
      for (int i = 0; i < 5; i++) need[i] <= unit[i] * 16'(qty_r);
    end
  end

  // Comparison uses pre-restock stock
  always_comb begin
    ok = (qty_r != '0);
    for (int i = 0; i < 5; i++)
      if (inv[i] < need[i]) ok = 1'b0;
  end

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      base[i] = take ? inv[i] - need[i] : inv[i];
      add[i]  = (bus.restock_valid && bus.restock_sel == 3'(i))
              ? bus.restock_amt : 16'd0;
      sum[i]  = {1'b0, base[i]} + {1'b0, add[i]};
      inv_nx[i] = sum[i][16] ? 16'hFFFF : sum[i][15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state == IDLE) begin
      for (int i = 0; i < 5; i++) inv[i] <= init_inv(i);
    end else if (state != TOTAL) begin
      for (int i = 0; i < 5; i++) inv[i] <= inv_nx[i];
    end
  end

  assign cnt_sum = {1'b0, cnt[type_r]} + (CNT_W+1)'(qty_r);

  always_ff @(posedge clk) begin
    if (rst || state == IDLE) begin
      for (int j = 0; j < 4; j++) cnt[j] <= '0;
    end else if (take) begin
      cnt[type_r] <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state == IDLE) begin
      low_q <= '0;
    end else begin
      for (int i = 0; i < 5; i++) low_q[i] <= (inv[i] < 16'(LOW_THR));
    end
  end

  assign gain = GAIN_W'(cnt[0]) * GAIN_W'(PRICE_T)
              + GAIN_W'(cnt[1]) * GAIN_W'(PRICE_TS)
              + GAIN_W'(cnt[2]) * GAIN_W'(PRICE_M)
              + GAIN_W'(cnt[3]) * GAIN_W'(PRICE_MS);

  always_comb begin
    bus.order_ready     = (state == OPEN);
    bus.out_valid_order = (state == DECIDE);
    bus.success         = take;
    bus.out_valid_tot   = (state == TOTAL);
    bus.sold_num        = '0;
    bus.total_gain      = '0;
    bus.low_stock       = low_q;
    if (state == TOTAL) begin
      bus.sold_num   = {cnt[0], cnt[1], cnt[2], cnt[3]};
      bus.total_gain = gain;
    end
  end

endmodule

// File: tb/tb_ramen_order_engine.sv
// Randomized bench for ramen_order_engine against a transaction-level
// stock and sales model.
module tb_ramen_order_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ramen_order_engine_if bus ();

  ramen_order_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  int inv_m [5];
  int cnt_m [4];
  // grams per serving [portion][type][noodle,broth,tonkotsu,miso,soy]
  int rec [2][4][5] = '{
    '{'{100, 300, 150,  0,  0},
      '{100, 300, 100,  0, 30},
      '{100, 400,   0, 30,  0},
      '{100, 300,  70, 15, 15}},
    '{'{150, 500, 200,  0,  0},
      '{150, 500, 150,  0, 50},
      '{150, 650,   0, 50,  0},
      '{150, 500, 100, 25, 25}}
  };
  int price [4] = '{200, 250, 200, 250};
  int init_m [5] = '{12000, 41000, 9000, 1000, 1500};

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_open();
    for (int i = 0; i < 5; i++) inv_m[i] = init_m[i];
    for (int j = 0; j < 4; j++) cnt_m[j] = 0;
  endfunction

  function automatic void m_restock(int sel, int amt);
    if (sel < 5) inv_m[sel] = (inv_m[sel] + amt > 65535)
                            ? 65535 : inv_m[sel] + amt;
  endfunction

  function automatic bit m_order(int ty, int po, int q);
    bit ok = (q != 0);
    for (int i = 0; i < 5; i++)
      if (inv_m[i] < q * rec[po][ty][i]) ok = 1'b0;
    if (ok) begin
      for (int i = 0; i < 5; i++) inv_m[i] -= q * rec[po][ty][i];
      cnt_m[ty] = (cnt_m[ty] + q > 255) ? 255 : cnt_m[ty] + q;
    end
    return ok;
  endfunction

  function automatic logic [4:0] m_low();
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = (inv_m[i] < 1000);
    return r;
  endfunction

  function automatic logic [31:0] m_sold();
    return {8'(cnt_m[0]), 8'(cnt_m[1]), 8'(cnt_m[2]), 8'(cnt_m[3])};
  endfunction

  function automatic int m_gain();
    int g = 0;
    for (int j = 0; j < 4; j++) g += cnt_m[j] * price[j];
    return g;
  endfunction

  task automatic open_shop();
    bus.selling = 1'b1;
    tick();
    m_open();
    chk("open_ready", bus.order_ready, 1);
    chk("open_low", bus.low_stock, 0);
  endtask

  task automatic close_shop();
    bus.selling  = 1'b0;
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.qty      = 3'($urandom_range(1, 7));
    tick();
    bus.in_valid = 1'b0;
    chk("tot_valid", bus.out_valid_tot, 1);
    chk("tot_sold", bus.sold_num, m_sold());
    chk("tot_gain", bus.total_gain, m_gain());
    tick();
    chk("tot_pulse", bus.out_valid_tot, 0);
    chk("tot_sold0", bus.sold_num, 0);
  endtask

  task automatic idle_restock(input int sel, input int amt);
    bus.restock_valid = 1'b1;
    bus.restock_sel   = 3'(sel);
    bus.restock_amt   = 16'(amt);
    tick();
    bus.restock_valid = 1'b0;
    m_restock(sel, amt);
  endtask

  task automatic do_order(input int ty, input int po, input int q,
                          input bit drs, input int dsel, input int damt,
                          input bit spur);
    bit ok;
    chk("ready", bus.order_ready, 1);
    bus.in_valid   = 1'b1;
    bus.ramen_type = 2'(ty);
    bus.portion    = 1'(po);
    bus.qty        = 3'(q);
    tick();
    chk("busy_chk", bus.order_ready, 0);
    bus.in_valid = spur;
    if (spur) begin
      bus.ramen_type = 2'($urandom_range(0, 3));
      bus.qty        = 3'($urandom_range(0, 7));
    end
    tick();
    bus.in_valid = 1'b0;
    ok = m_order(ty, po, q);
    chk("ov", bus.out_valid_order, 1);
    chk("busy_dec", bus.order_ready, 0);
    chk("success", bus.success, ok);
    if (drs) begin
      bus.restock_valid = 1'b1;
      bus.restock_sel   = 3'(dsel);
      bus.restock_amt   = 16'(damt);
      m_restock(dsel, damt);
    end
    tick();
    bus.restock_valid = 1'b0;
    chk("ov_pulse", bus.out_valid_order, 0);
    chk("success0", bus.success, 0);
    tick();
    chk("low_stock", bus.low_stock, m_low());
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_ready"}, bus.order_ready, 0);
    chk({tag, "_ov"}, bus.out_valid_order, 0);
    chk({tag, "_succ"}, bus.success, 0);
    chk({tag, "_tot"}, bus.out_valid_tot, 0);
    chk({tag, "_sold"}, bus.sold_num, 0);
    chk({tag, "_gain"}, bus.total_gain, 0);
    chk({tag, "_low"}, bus.low_stock, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bus.selling       = 1'b0;
    bus.in_valid      = 1'b0;
    bus.ramen_type    = '0;
    bus.portion       = 1'b0;
    bus.qty           = '0;
    bus.restock_valid = 1'b0;
    bus.restock_sel   = '0;
    bus.restock_amt   = '0;
    m_open();

    tick();
    tick();
    all_zero("rst");
    rst = 1'b0;
    tick();
    all_zero("idle");

    // Open and close at once
    open_shop();
    close_shop();

    // Miso runs dry on the third large order
    open_shop();
    for (int k = 0; k < 3; k++) do_order(2, 1, 7, 0, 0, 0, 0);
    close_shop();

    // Same-cycle deduction and restock on miso
    open_shop();
    do_order(3, 0, 5, 1, 3, 500, 1);
    idle_restock(1, 65535);
    idle_restock(6, $urandom_range(1, 65535));
    do_order(0, 1, 0, 0, 0, 0, 1);

    // Random orders and restocks over several sessions
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 25; k++) begin
        int n_idle = $urandom_range(0, 2);
        for (int m = 0; m < n_idle; m++)
          idle_restock($urandom_range(0, 7),
                       ($urandom_range(0, 9) == 0) ? 65535
                                                    : $urandom_range(0, 2500));
        do_order($urandom_range(0, 3), $urandom_range(0, 1),
                 $urandom_range(0, 7), ($urandom_range(0, 2) == 0),
                 $urandom_range(0, 7), $urandom_range(0, 3000),
                 1'($urandom_range(0, 1)));
      end
      close_shop();
      open_shop();
    end
    close_shop();

    // Tonkotsu counter saturates with the stock kept topped up
    open_shop();
    for (int k = 0; k < 46; k++) do_order(0, 1, 7, 1, k % 3, 65535, 0);
    close_shop();

    // Reset mid-CHECK drops the order and the totals
    open_shop();
    bus.in_valid   = 1'b1;
    bus.ramen_type = 2'd0;
    bus.portion    = 1'b1;
    bus.qty        = 3'd7;
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    all_zero("midrst");
    bus.selling = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("no_tot", bus.out_valid_tot, 0);
    end
    open_shop();
    close_shop();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
